// File: rtl/priority_stream_mux_if.sv
// Bundle of the N source streams plus the single registered output stream of priority_stream_mux.
// The master side drives the sources and the consumer ready; the slave side is the mux itself.
interface priority_stream_mux_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [DATA_WIDTH-1:0]              out_data_o;
  logic [SRC_W-1:0]                   out_src_o;
  logic                               out_valid_o;
  logic                               out_ready_i;

  modport master (
    output req_data_i, req_valid_i, out_ready_i,
    input  req_ready_o, out_data_o, out_src_o, out_valid_o
  );

  modport slave (
    input  req_data_i, req_valid_i, out_ready_i,
    output req_ready_o, out_data_o, out_src_o, out_valid_o
  );
endinterface

// File: rtl/priority_stream_mux.sv
// Registered N-to-1 fixed-priority stream mux with a starvation guard; index 0 wins unless someone starved.
// Latency 1 cycle source handshake to out_valid_o; a stalled output holds its word and drops every ready.
module priority_stream_mux #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 7
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  priority_stream_mux_if.slave  bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    starved;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    hs;
  logic [SRC_W-1:0]      sel_idx;
  logic                  found;
  logic                  can_accept;
  logic                  take;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0]      out_src_q;
  logic                  out_valid_q;

  assign can_accept = ~out_valid_q | bus.out_ready_i;

  // Starved requesters are scanned first; only if none exists does plain priority apply.
  always_comb begin
    grant   = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && starved[i]) begin
        grant[i] = 1'b1;
        sel_idx  = SRC_W'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid_i[i]) begin
        grant[i] = 1'b1;
        sel_idx  = SRC_W'(i);
        found    = 1'b1;
      end
    end
  end

  // Reset gating keeps sources from seeing a handshake while the output register is held clear.
  assign bus.req_ready_o = grant & {NUM_REQ{can_accept & ~arst_i}};
  assign hs              = bus.req_valid_i & bus.req_ready_o;
  assign take            = |hs;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (take) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.req_data_i[sel_idx];
      out_src_q   <= sel_idx;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  generate
    if (MAX_WAIT != 0) begin : g_wait
      localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

      logic [CNT_W-1:0] wait_cnt [NUM_REQ];

      // Stall cycles count as waiting, so counters keep running while the output is blocked.
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid_i[i] || hs[i]) wait_cnt[i] <= '0;
            else if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
          end
        end
      end

      always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++)
          starved[i] = bus.req_valid_i[i] && (wait_cnt[i] == CNT_MAX);
      end
    end else begin : g_no_wait
      assign starved = '0;
    end
  endgenerate

  assign bus.out_data_o  = out_data_q;
  assign bus.out_src_o   = out_src_q;
  assign bus.out_valid_o = out_valid_q;
endmodule

// File: tb/tb_priority_stream_mux.sv
// Directed bench for priority_stream_mux (4 sources, 8-bit data, MAX_WAIT=7) with hand-computed expectations.
module tb_priority_stream_mux;
  logic clk;
  logic arst;
  int   total = 0;
  int   bad   = 0;

  priority_stream_mux_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  priority_stream_mux #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_WAIT(7)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here, outputs checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] dat, input logic [1:0] src);
    check({tag, ".vld"}, 32'(bus.out_valid_o), 32'h1);
    check({tag, ".dat"}, 32'(bus.out_data_o), 32'(dat));
    check({tag, ".src"}, 32'(bus.out_src_o), 32'(src));
  endtask

  initial begin
    arst            = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.out_ready_i = 1'b0;
    #2;
    check("rst_vld", 32'(bus.out_valid_o), 32'h0);
    check("rst_rdy", 32'(bus.req_ready_o), 32'h0);
    tick();
    tick();
    arst = 1'b0;
    tick();

    // Fixed priority: src1 beats src3, then src3 once src1 drops.
    bus.req_data_i[1] = 8'h11;
    bus.req_data_i[3] = 8'h33;
    bus.req_valid_i   = 4'b1010;
    bus.out_ready_i   = 1'b1;
    #1;
    check("prio_rdy0", 32'(bus.req_ready_o), 32'h2);
    check("prio_vld0", 32'(bus.out_valid_o), 32'h0);
    tick();
    bus.req_valid_i = 4'b1000;
    #1;
    check_out("prio_w1", 8'h11, 2'd1);
    check("prio_rdy1", 32'(bus.req_ready_o), 32'h8);
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    check_out("prio_w3", 8'h33, 2'd3);
    check("prio_rdy2", 32'(bus.req_ready_o), 32'h0);
    tick();
    #1;
    check("prio_drain", 32'(bus.out_valid_o), 32'h0);

    // Back-to-back: src0 streams 1..8 with no bubbles.
    for (int k = 1; k <= 8; k++) begin
      bus.req_data_i[0] = 8'(k);
      bus.req_valid_i   = 4'b0001;
      #1;
      check("bb_rdy", 32'(bus.req_ready_o), 32'h1);
      if (k > 1) check_out("bb_out", 8'(k - 1), 2'd0);
      tick();
    end
    bus.req_valid_i = 4'b0000;
    #1;
    check_out("bb_last", 8'h08, 2'd0);
    tick();
    #1;
    check("bb_drain", 32'(bus.out_valid_o), 32'h0);

    // Backpressure: load A0, then hold the consumer off for 5 cycles.
    bus.req_data_i[0] = 8'hA0;
    bus.req_valid_i   = 4'b0001;
    tick();
    bus.out_ready_i   = 1'b0;
    bus.req_data_i[0] = 8'hA1;
    bus.req_data_i[2] = 8'hC2;
    bus.req_valid_i   = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rdy", 32'(bus.req_ready_o), 32'h0);
      check_out("bp_hold", 8'hA0, 2'd0);
      tick();
    end
    bus.out_ready_i = 1'b1;
    #1;
    check("bp_release_rdy", 32'(bus.req_ready_o), 32'h1);
    tick();
    bus.req_valid_i = 4'b0100;
    #1;
    check_out("bp_a1", 8'hA1, 2'd0);
    check("bp_rdy2", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    check_out("bp_c2", 8'hC2, 2'd2);
    tick();

    // Starvation: src3 waits 7 cycles behind a permanently valid src0.
    bus.req_data_i[0] = 8'h50;
    bus.req_data_i[3] = 8'hD3;
    bus.req_valid_i   = 4'b1001;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("sv_rdy_src0", 32'(bus.req_ready_o), 32'h1);
      tick();
    end
    #1;
    check("sv_rdy_src3", 32'(bus.req_ready_o), 32'h8);
    tick();
    bus.req_valid_i = 4'b0001;
    #1;
    check_out("sv_w3", 8'hD3, 2'd3);
    check("sv_rdy_resume", 32'(bus.req_ready_o), 32'h1);
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    check_out("sv_w0", 8'h50, 2'd0);
    tick();

    // Simultaneous starvation: src2 then src3 then src0.
    bus.req_data_i[0] = 8'h60;
    bus.req_data_i[2] = 8'hE2;
    bus.req_data_i[3] = 8'hF3;
    bus.req_valid_i   = 4'b1101;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("ss_rdy_src0", 32'(bus.req_ready_o), 32'h1);
      tick();
    end
    #1;
    check("ss_rdy_src2", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = 4'b1001;
    #1;
    check("ss_rdy_src3", 32'(bus.req_ready_o), 32'h8);
    check_out("ss_w2", 8'hE2, 2'd2);
    tick();
    bus.req_valid_i = 4'b0001;
    #1;
    check("ss_rdy_src0b", 32'(bus.req_ready_o), 32'h1);
    check_out("ss_w3", 8'hF3, 2'd3);
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    check_out("ss_w0", 8'h60, 2'd0);
    tick();

    // Reset mid-stream with a stalled word from src1 pending.
    bus.out_ready_i   = 1'b0;
    bus.req_data_i[1] = 8'h77;
    bus.req_valid_i   = 4'b0010;
    #1;
    tick();
    #1;
    check_out("mr_pre", 8'h77, 2'd1);
    bus.out_ready_i = 1'b1;
    arst            = 1'b1;
    #1;
    check("mr_vld", 32'(bus.out_valid_o), 32'h0);
    check("mr_src", 32'(bus.out_src_o), 32'h0);
    check("mr_dat", 32'(bus.out_data_o), 32'h0);
    check("mr_rdy", 32'(bus.req_ready_o), 32'h0);
    bus.req_valid_i = 4'b0000;
    tick();
    arst = 1'b0;
    tick();
    tick();
    #1;
    check("post_vld", 32'(bus.out_valid_o), 32'h0);
    check("post_src", 32'(bus.out_src_o), 32'h0);
    check("post_rdy", 32'(bus.req_ready_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/priority_stream_mux.md
Name: priority_stream_mux

Overview:
- Registered N-to-1 valid/ready stream multiplexer.
- Selects one source per cycle by fixed priority, with index 0 the highest.
- Includes a starvation guard that temporarily promotes any requester that has waited too long.
- Sits directly downstream of the request sources and feeds one shared consumer, e.g. a writeback port or a memory request queue. It is the sequential wrapper around fixed-priority grant generation.

Parameters:
- NUM_REQ, 4: number of source streams; must be >= 2.
- DATA_WIDTH, 8: payload width per source.
- MAX_WAIT, 7: consecutive stalled cycles after which a source is marked starved; 0 disables the guard.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- arst_i  input  1  asynchronous active-high reset.
- req_data_i  input  NUM_REQ x DATA_WIDTH  per-source payload; element i belongs to source i.
- req_valid_i  input  NUM_REQ  per-source valid.
- req_ready_o  output  NUM_REQ  per-source ready; at most one bit is high per cycle.
- out_data_o  output  DATA_WIDTH  registered selected payload.
- out_src_o  output  max(1,$clog2(NUM_REQ))  registered index of the source that produced out_data_o.
- out_valid_o  output  1  output valid.
- out_ready_i  input  1  consumer ready.

Behaviour:
- Interface:
  - One clock, clk_i.
  - Reset arst_i is asynchronous, active-high.
- Reset values (take effect immediately on arst_i assertion):
  - out_valid_o=0, out_data_o=0, out_src_o=0.
  - All wait counters=0.
  - req_ready_o=0 for as long as arst_i is high.
- Stage-accept condition:
  - can_accept = ~out_valid_o | out_ready_i.
  - The single output register is free, or is being drained in the same cycle.
- Selection (combinational, same cycle):
  - starved[i] = (MAX_WAIT!=0) & (wait_cnt[i]==MAX_WAIT) & req_valid_i[i].
  - If any starved bit is set, grant the lowest-index starved source.
  - Otherwise grant the lowest-index source with req_valid_i set.
  - The grant vector is one-hot or all-zero.
- Ready:
  - req_ready_o = grant & {NUM_REQ{can_accept}}.
  - Ready may depend combinationally on req_valid_i and out_ready_i.
  - Ready never depends on req_data_i.
- Source handshake:
  - Occurs when req_valid_i[i] & req_ready_o[i].
  - On the next edge: out_data_o <= req_data_i[i], out_src_o <= i, out_valid_o <= 1.
  - Latency is 1 cycle from source handshake to out_valid_o.
- Output drain:
  - Occurs when out_valid_o & out_ready_i.
  - If there is no source handshake in the same cycle, out_valid_o <= 0.
  - Simultaneous drain and source handshake: the register reloads and out_valid_o stays 1. This sustains full throughput of 1 transfer per cycle.
- Stall:
  - When out_valid_o=1 and out_ready_i=0, out_data_o and out_src_o are held stable.
  - All req_ready_o bits are 0 during a stall.
- Source rules:
  - Sources hold valid and data until they see ready.
  - The block does not check this.
  - A source dropping valid without a handshake is legal; its wait counter clears.
- Wait counters:
  - One per source, width $clog2(MAX_WAIT+1).
  - Cleared when req_valid_i[i]=0 or when source i handshakes.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Counters advance during output stalls too, because a stall counts as waiting.
- Starved source:
  - Keeps priority until it handshakes; its counter then clears.
  - With multiple starved sources, the lowest index is served first; the others remain starved.
- MAX_WAIT=0: the counters are absent and arbitration is pure fixed priority.
- No combinational path from req_data_i to any output.
- Reset mid-transfer: any pending output word is discarded, with no handshake reported to the consumer after reset.

Test Plan:
- Reset:
  - Stimulus: assert arst_i mid-stream with out_valid_o=1.
  - Required: out_valid_o=0, out_src_o=0 and req_ready_o=0 immediately, without waiting for a clock edge. After release with no requests, outputs remain 0.
- Fixed priority:
  - Stimulus: req_valid_i=4'b1010 with data src1=8'h11, src3=8'h33; out_ready_i=1.
  - Required: req_ready_o=4'b0010. The next cycle gives out_data_o=8'h11, out_src_o=1.
  - Then drop src1: req_ready_o=4'b1000, and the next cycle gives 8'h33, src 3.
- Back-to-back throughput:
  - Stimulus: src0 streams 8'h01..8'h08, out_ready_i held 1.
  - Required: 8 consecutive out_valid_o cycles with data in order and no bubbles.
- Backpressure:
  - Stimulus: out_ready_i=0 for 5 cycles with out_valid_o=1 and src0 and src2 valid.
  - Required: output is held stable and req_ready_o=0 throughout.
  - When out_ready_i rises, src0 is granted in the same cycle (its counter is not yet saturated).
- Starvation:
  - Stimulus: MAX_WAIT=7; src0 always valid, src3 valid from cycle 0; out_ready_i=1.
  - Required: src3 is granted after exactly 7 stalled cycles, the src3 word appears in cycle 8, and src0 resumes the next cycle.
- Simultaneous starvation:
  - Stimulus: src2 and src3 both reach MAX_WAIT while src0 stays valid.
  - Required: src2 is served, then src3, then src0.
